// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined RISC CPU.
// Holds the datapath widths, flag bit positions and the EX/MEM entry layout.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  z;
        logic                  v;
        logic                  n;
        logic                  set_flags;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
        logic                  mem_re;
        logic                  mem_we;
        logic [DATA_W-1:0]     store_data;
    } ex_mem_entry_t;

    localparam int ENTRY_W = $bits(ex_mem_entry_t);

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer: a main register that drives the
// output and a skid register that absorbs one beat while the output is held.
module skid_buffer2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q;
    logic         accept;
    logic         main_free;

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            // Anything in flight, including a beat offered this cycle, is dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_d       = accept ? in_data : main_q;
                main_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: buffers ALU results towards MEM and commits the
// architectural Z/V/N flags plus a sticky overflow bit as entries retire.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_negative,
    input  logic                  set_flags,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_we,
    input  logic                  mem_re,
    input  logic                  mem_we,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_we,
    output logic                  out_mem_re,
    output logic                  out_mem_we,
    output logic [DATA_W-1:0]     out_store_data,
    output logic                  flag_z,
    output logic                  flag_v,
    output logic                  flag_n,
    output logic                  ovf_sticky,
    input  logic                  ovf_clear
);

    ex_mem_entry_t in_entry;
    ex_mem_entry_t out_entry;
    logic          retire;
    logic [2:0]    flags_q, flags_d;
    logic          sticky_q, sticky_d;

    always_comb begin
        in_entry            = '0;
        in_entry.result     = alu_result;
        in_entry.z          = alu_zero;
        in_entry.v          = alu_overflow;
        in_entry.n          = alu_negative;
        in_entry.set_flags  = set_flags;
        in_entry.rd         = rd;
        in_entry.reg_we     = reg_we;
        // A simultaneous load and store is meaningless; neutralise both.
        in_entry.mem_re     = mem_re && !mem_we;
        in_entry.mem_we     = mem_we && !mem_re;
        in_entry.store_data = store_data;
    end

    skid_buffer2 #(
        .W(ENTRY_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_entry)
    );

    assign retire = out_valid && out_ready;

    always_comb begin
        flags_d  = flags_q;
        sticky_d = sticky_q;
        if (retire && out_entry.set_flags) begin
            flags_d[FLAG_Z] = out_entry.z;
            flags_d[FLAG_V] = out_entry.v;
            flags_d[FLAG_N] = out_entry.n;
        end
        // Setting has priority over a same-cycle clear.
        if (retire && out_entry.v) begin
            sticky_d = 1'b1;
        end else if (ovf_clear) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_result     = out_entry.result;
    assign out_rd         = out_entry.rd;
    assign out_reg_we     = out_entry.reg_we;
    assign out_mem_re     = out_entry.mem_re;
    assign out_mem_we     = out_entry.mem_we;
    assign out_store_data = out_entry.store_data;
    assign flag_z         = flags_q[FLAG_Z];
    assign flag_v         = flags_q[FLAG_V];
    assign flag_n         = flags_q[FLAG_N];
    assign ovf_sticky     = sticky_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed stimulus pushes expected entries,
// a negedge monitor pops and compares each retiring entry.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic        alu_zero, alu_overflow, alu_negative, set_flags;
    logic [2:0]  rd;
    logic        reg_we, mem_re, mem_we;
    logic [15:0] store_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_reg_we, out_mem_re, out_mem_we;
    logic [15:0] out_store_data;
    logic        flag_z, flag_v, flag_n, ovf_sticky, ovf_clear;

    int checks   = 0;
    int failures = 0;
    ex_mem_entry_t exp_q[$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .set_flags(set_flags), .rd(rd), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .store_data(store_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
        .out_mem_we(out_mem_we), .out_store_data(out_store_data),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every retiring entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL retire_unexpected: got result 0x%0h expected no entry", out_result);
            end else begin
                ex_mem_entry_t e;
                e = exp_q.pop_front();
                if (out_result !== e.result || out_rd !== e.rd || out_reg_we !== e.reg_we ||
                    out_mem_re !== e.mem_re || out_mem_we !== e.mem_we ||
                    out_store_data !== e.store_data) begin
                    failures++;
                    $display("FAIL retire: got res=%h rd=%0d we=%b re=%b mwe=%b sd=%h expected res=%h rd=%0d we=%b re=%b mwe=%b sd=%h",
                             out_result, out_rd, out_reg_we, out_mem_re, out_mem_we, out_store_data,
                             e.result, e.rd, e.reg_we, e.mem_re, e.mem_we, e.store_data);
                end else begin
                    $display("ok   retire: res=0x%0h rd=%0d", out_result, out_rd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] res, input logic z, input logic v, input logic n,
                         input logic sf, input logic [2:0] r, input logic we,
                         input logic re, input logic mwe, input logic [15:0] sd);
        in_valid = 1'b1; alu_result = res; alu_zero = z; alu_overflow = v; alu_negative = n;
        set_flags = sf; rd = r; reg_we = we; mem_re = re; mem_we = mwe; store_data = sd;
    endtask

    task automatic expect_entry(input logic [15:0] res, input logic [2:0] r, input logic we,
                                input logic re, input logic mwe, input logic [15:0] sd);
        ex_mem_entry_t e;
        e = '0;
        e.result = res; e.rd = r; e.reg_we = we; e.mem_re = re; e.mem_we = mwe; e.store_data = sd;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; alu_zero = 0; alu_overflow = 0;
        alu_negative = 0; set_flags = 0; rd = '0; reg_we = 0; mem_re = 0; mem_we = 0;
        store_data = '0; flush = 0; out_ready = 0; ovf_clear = 0;
        step(); step();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        check("reset_flags", {flag_z, flag_v, flag_n, ovf_sticky}, 0);
        reset = 1'b0;
        step();
        check("post_reset_in_ready", in_ready, 1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(16'(i), 0, 0, 0, 0, 3'(i), 1, 0, 0, 16'(i * 16));
            check("stream_in_ready", in_ready, 1);
            expect_entry(16'(i), 3'(i), 1, 0, 0, 16'(i * 16));
            step();
            check("stream_latency", {out_valid, out_result}, {1'b1, 16'(i)});
        end
        in_valid = 1'b0;
        step(); step();
        check("stream_drained", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        offer(16'h0001, 0, 0, 0, 0, 3'd1, 1, 0, 0, 16'h1111);
        expect_entry(16'h0001, 3'd1, 1, 0, 0, 16'h1111);
        step();
        check("bp_in_ready_c2", in_ready, 1);
        offer(16'h0002, 0, 0, 0, 0, 3'd2, 1, 0, 0, 16'h2222);
        expect_entry(16'h0002, 3'd2, 1, 0, 0, 16'h2222);
        step();
        check("bp_in_ready_c3", in_ready, 0);
        offer(16'h0003, 0, 0, 0, 0, 3'd3, 1, 0, 0, 16'h3333);
        step();
        in_valid = 1'b0;
        check("bp_hold_result", {out_valid, out_result}, {1'b1, 16'h0001});
        step();
        check("bp_hold_stable", {out_result, out_store_data}, {16'h0001, 16'h1111});
        check("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("bp_skid_to_main", out_result, 16'h0002);
        check("bp_in_ready_rises", in_ready, 1);
        step();
        check("bp_empty", out_valid, 0);

        // Flags
        offer(16'h8000, 0, 1, 1, 1, 3'd1, 1, 0, 0, 16'h0);
        expect_entry(16'h8000, 3'd1, 1, 0, 0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check("flags_vn", {flag_z, flag_v, flag_n}, 3'b011);
        check("sticky_set", ovf_sticky, 1);
        offer(16'h0000, 1, 0, 0, 0, 3'd2, 1, 0, 0, 16'h0);
        expect_entry(16'h0000, 3'd2, 1, 0, 0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check("flags_unchanged", {flag_z, flag_v, flag_n}, 3'b011);
        offer(16'h0000, 1, 0, 0, 1, 3'd3, 1, 0, 0, 16'h0);
        expect_entry(16'h0000, 3'd3, 1, 0, 0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check("flags_z", {flag_z, flag_v, flag_n}, 3'b100);
        check("sticky_kept", ovf_sticky, 1);

        // Sticky race
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("sticky_cleared", ovf_sticky, 0);
        offer(16'h7FFF, 0, 1, 0, 0, 3'd4, 1, 0, 0, 16'h0);
        expect_entry(16'h7FFF, 3'd4, 1, 0, 0, 16'h0);
        step();
        in_valid = 1'b0;
        ovf_clear = 1'b1;
        step();
        check("sticky_set_wins", ovf_sticky, 1);
        check("sticky_no_flag_commit", {flag_z, flag_v, flag_n}, 3'b100);
        step();
        ovf_clear = 1'b0;
        check("sticky_clear_alone", ovf_sticky, 0);

        // Flush with both entries buffered
        out_ready = 1'b0;
        offer(16'h00A1, 0, 0, 0, 1, 3'd1, 1, 0, 0, 16'h0);
        step();
        offer(16'h00B2, 0, 0, 1, 1, 3'd2, 1, 0, 0, 16'h0);
        step();
        offer(16'h00C3, 0, 1, 1, 1, 3'd3, 1, 0, 0, 16'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step(); step();
        check("flush_nothing_retired", out_valid, 0);
        check("flush_flags_kept", {flag_z, flag_v, flag_n, ovf_sticky}, 4'b1000);

        // Flush discards a beat accepted in the flush cycle
        out_ready = 1'b0;
        offer(16'h00D4, 0, 0, 0, 0, 3'd4, 1, 0, 0, 16'h0);
        step();
        offer(16'h00E5, 0, 0, 0, 0, 3'd5, 1, 0, 0, 16'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_accept_discarded", out_valid, 0);
        step();
        check("flush_accept_stays_empty", out_valid, 0);

        // Reset with buffer full
        out_ready = 1'b0;
        offer(16'h0F0F, 0, 1, 0, 1, 3'd6, 1, 0, 0, 16'h5555);
        step();
        offer(16'h1F1F, 0, 1, 1, 1, 3'd7, 1, 0, 0, 16'h6666);
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        step();
        check("rst_outputs", {in_ready, out_valid, out_result, out_rd, out_store_data}, 0);
        check("rst_flags", {flag_z, flag_v, flag_n, ovf_sticky, out_reg_we, out_mem_re, out_mem_we}, 0);
        reset = 1'b0;
        step();
        check("rst_release_in_ready", in_ready, 1);
        check("rst_release_out_valid", out_valid, 0);

        // Illegal control: load and store together
        out_ready = 1'b1;
        offer(16'h1234, 0, 0, 0, 0, 3'd5, 1, 1, 1, 16'hBEEF);
        expect_entry(16'h1234, 3'd5, 1, 0, 0, 16'hBEEF);
        step();
        in_valid = 1'b0;
        check("illegal_ctrl", {out_valid, out_reg_we, out_mem_re, out_mem_we}, 4'b1100);
        offer(16'h4321, 0, 0, 0, 0, 3'd2, 0, 0, 1, 16'hCAFE);
        expect_entry(16'h4321, 3'd2, 0, 0, 1, 16'hCAFE);
        step();
        in_valid = 1'b0;
        check("store_ctrl", {out_valid, out_reg_we, out_mem_re, out_mem_we}, 4'b1001);
        step(); step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
